// File: rtl/ex_mem_pkg.sv
// Shared EX->MEM payload layout: field offsets, slot-occupancy states and
// pack/unpack helpers so EX and MEM agree on bit positions.
package ex_mem_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 6;

    // Bit-0-upward layout: halted, data_rw, data_mem_write, alu_output, write_addr
    localparam int F_HALTED    = 0;
    localparam int F_DATA_RW   = 1;
    localparam int F_MEM_WRITE = 2;
    localparam int F_ALU_LSB   = 3;
    localparam int F_ADDR_LSB  = F_ALU_LSB + DEF_DATA_W;
    localparam int PAYLOAD_W   = 3 + DEF_DATA_W + DEF_ADDR_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] write_addr;
        logic [DEF_DATA_W-1:0] alu_output;
        logic                  data_mem_write;
        logic                  data_rw;
        logic                  halted;
    } ex_mem_payload_t;

    function automatic int payload_width(input int data_w, input int addr_w);
        return 3 + data_w + addr_w;
    endfunction

    function automatic logic [PAYLOAD_W-1:0] pack_payload(input ex_mem_payload_t p);
        return p;
    endfunction

    function automatic ex_mem_payload_t unpack_payload(input logic [PAYLOAD_W-1:0] v);
        return v;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_stage_slot.sv
// One pipeline slot: a valid bit plus a payload register. Clear drops the
// entry but leaves the payload untouched so stale data stays visible.
module pipe_slot #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer, freeze, flush,
// sticky halt capture and a saturating bubble counter.
module ex_mem_pipe_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int BUBBLE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                freeze,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_halted,
    input  logic                in_data_rw,
    input  logic [DATA_W-1:0]   in_alu_output,
    input  logic [ADDR_W-1:0]   in_write_addr,
    input  logic                in_data_mem_write,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_halted,
    output logic                out_data_rw,
    output logic [DATA_W-1:0]   out_alu_output,
    output logic [ADDR_W-1:0]   out_write_addr,
    output logic                out_data_mem_write,
    output logic                halted_sticky,
    output logic [BUBBLE_W-1:0] bubble_cnt,
    output logic [1:0]          dbg_state
);

    localparam int PW       = payload_width(DATA_W, ADDR_W);
    localparam int ADDR_LSB = F_ALU_LSB + DATA_W;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high and neither freeze nor flush is asserted. in_ready depends only
    // on registered state, so upstream never sees a combinational ready path.
    logic          w_main_valid, w_skid_valid;
    logic [PW-1:0] w_main_data, w_skid_data, w_in_payload, w_main_src;
    logic          w_acc, w_tk, w_main_open;
    logic          w_main_load, w_main_clear, w_skid_load, w_skid_clear;
    slot_state_e   w_state;

    logic                r_halted_sticky;
    logic [BUBBLE_W-1:0] r_bubble_cnt;

    assign w_in_payload = {in_write_addr, in_alu_output, in_data_mem_write, in_data_rw, in_halted};

    assign in_ready  = !w_skid_valid && !r_halted_sticky;
    assign out_valid = w_main_valid;

    assign w_acc       = in_valid && in_ready && !freeze && !flush;
    assign w_tk        = w_main_valid && out_ready && !freeze && !flush;
    assign w_main_open = (!w_main_valid || w_tk) && !freeze && !flush;

    // Skid holds the older entry, so it always refills main first.
    assign w_main_src   = w_skid_valid ? w_skid_data : w_in_payload;
    assign w_main_load  = w_main_open && (w_skid_valid || w_acc);
    assign w_main_clear = flush || (w_tk && !w_skid_valid && !w_acc);
    assign w_skid_load  = w_acc && w_main_valid && (!w_tk || w_skid_valid);
    assign w_skid_clear = flush || (w_tk && w_skid_valid && !w_skid_load);

    pipe_slot #(.W(PW)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_src),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_payload),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    always_comb begin
        w_state = ST_EMPTY;
        if (w_skid_valid) begin
            w_state = ST_TWO;
        end else if (w_main_valid) begin
            w_state = ST_ONE;
        end
    end

    assign dbg_state = w_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted_sticky <= 1'b0;
            r_bubble_cnt    <= '0;
        end else if (!freeze) begin
            if (w_tk && w_main_data[F_HALTED]) begin
                r_halted_sticky <= 1'b1;
            end
            if (!w_main_valid && (r_bubble_cnt != {BUBBLE_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + {{(BUBBLE_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign halted_sticky      = r_halted_sticky;
    assign bubble_cnt         = r_bubble_cnt;
    assign out_halted         = w_main_data[F_HALTED];
    assign out_data_rw        = w_main_data[F_DATA_RW];
    assign out_data_mem_write = w_main_data[F_MEM_WRITE];
    assign out_alu_output     = w_main_data[F_ALU_LSB +: DATA_W];
    assign out_write_addr     = w_main_data[ADDR_LSB +: ADDR_W];

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage: handshake, skid ordering, freeze,
// flush, halt capture, bubble saturation and asynchronous reset.
module tb_ex_mem_pipe_stage;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 6;
    localparam int BUBBLE_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                freeze, flush;
    logic                in_valid, in_ready;
    logic                in_halted, in_data_rw, in_data_mem_write;
    logic [DATA_W-1:0]   in_alu_output;
    logic [ADDR_W-1:0]   in_write_addr;
    logic                out_valid, out_ready;
    logic                out_halted, out_data_rw, out_data_mem_write;
    logic [DATA_W-1:0]   out_alu_output;
    logic [ADDR_W-1:0]   out_write_addr;
    logic                halted_sticky;
    logic [BUBBLE_W-1:0] bubble_cnt;
    logic [1:0]          dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    ex_mem_pipe_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUBBLE_W(BUBBLE_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .freeze             (freeze),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_halted          (in_halted),
        .in_data_rw         (in_data_rw),
        .in_alu_output      (in_alu_output),
        .in_write_addr      (in_write_addr),
        .in_data_mem_write  (in_data_mem_write),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_halted         (out_halted),
        .out_data_rw        (out_data_rw),
        .out_alu_output     (out_alu_output),
        .out_write_addr     (out_write_addr),
        .out_data_mem_write (out_data_mem_write),
        .halted_sticky      (halted_sticky),
        .bubble_cnt         (bubble_cnt),
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        freeze = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_halted = 1'b0; in_data_rw = 1'b0; in_data_mem_write = 1'b0;
        in_alu_output = '0; in_write_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [DATA_W-1:0] alu, input logic [ADDR_W-1:0] addr, input logic halt);
        in_valid = 1'b1; in_alu_output = alu; in_write_addr = addr; in_halted = halt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, rcv, low;
        logic [DATA_W-1:0] exp;

        // Reset values and bubble saturation
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sticky", halted_sticky, 0);
        check("rst_bubble", bubble_cnt, 0);
        check("rst_alu", out_alu_output, 0);
        check("rst_state", dbg_state, 0);
        repeat (20) tick();
        check("bubble_sat", bubble_cnt, 15);
        repeat (3) tick();
        check("bubble_hold", bubble_cnt, 15);

        // Single entry, one-cycle latency
        do_reset();
        out_ready = 1'b1;
        send(8'h5A, 6'h11, 1'b0);
        in_data_rw = 1'b1; in_data_mem_write = 1'b1;
        tick();
        in_valid = 1'b0; in_data_rw = 1'b0; in_data_mem_write = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_alu", out_alu_output, 8'h5A);
        check("single_addr", out_write_addr, 6'h11);
        check("single_rw", out_data_rw, 1);
        check("single_mw", out_data_mem_write, 1);
        check("single_state", dbg_state, 1);
        tick();
        check("single_taken", out_valid, 0);
        check("single_stale", out_alu_output, 8'h5A);
        check("single_bubble", bubble_cnt, 1);

        // Stream of 8 with out_ready low for one cycle at item 3
        do_reset();
        idx = 0; rcv = 0; low = 0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            out_ready = (cyc != 3);
            if (idx < 8) send(8'(idx + 1), 6'(idx), 1'b0);
            else in_valid = 1'b0;
            if (!in_ready) low++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", out_alu_output, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("stream_data", out_alu_output, exp);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(8'(idx + 1));
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_count", rcv, 8);
        check("stream_ready_low", low, 1);

        // Fill both slots, then freeze with downstream ready
        do_reset();
        out_ready = 1'b0;
        send(8'hA1, 6'h01, 1'b0);
        tick();
        send(8'hA2, 6'h02, 1'b0);
        tick();
        send(8'hEE, 6'h3F, 1'b0);
        check("fill_state", dbg_state, 2);
        check("fill_in_ready", in_ready, 0);
        check("fill_bubble", bubble_cnt, 1);
        freeze = 1'b1; out_ready = 1'b1;
        repeat (4) begin
            tick();
            check("freeze_valid", out_valid, 1);
            check("freeze_alu", out_alu_output, 8'hA1);
            check("freeze_in_ready", in_ready, 0);
        end
        check("freeze_bubble", bubble_cnt, 1);
        check("freeze_state", dbg_state, 2);

        // Flush while frozen kills both slots
        flush = 1'b1;
        tick();
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_state", dbg_state, 0);
        check("flush_stale", out_alu_output, 8'hA1);

        // Halt capture blocks further input
        do_reset();
        out_ready = 1'b1;
        send(8'h77, 6'h07, 1'b1);
        tick();
        in_valid = 1'b0; in_halted = 1'b0;
        check("halt_out_valid", out_valid, 1);
        check("halt_out_halted", out_halted, 1);
        check("halt_not_yet", halted_sticky, 0);
        tick();
        check("halt_sticky", halted_sticky, 1);
        check("halt_in_ready", in_ready, 0);
        check("halt_drained", out_valid, 0);
        send(8'h33, 6'h33, 1'b0);
        repeat (3) begin
            tick();
            check("halt_block_valid", out_valid, 0);
        end
        check("halt_block_alu", out_alu_output, 8'h77);
        in_valid = 1'b0;

        // Flush in the cycle a halt would be taken: sticky stays clear
        do_reset();
        out_ready = 1'b0;
        send(8'h44, 6'h04, 1'b1);
        tick();
        in_valid = 1'b0; in_halted = 1'b0;
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flushhalt_sticky", halted_sticky, 0);
        check("flushhalt_valid", out_valid, 0);
        check("flushhalt_in_ready", in_ready, 1);

        // Asynchronous reset mid-transfer
        do_reset();
        out_ready = 1'b0;
        send(8'h12, 6'h12, 1'b0);
        tick();
        send(8'h13, 6'h13, 1'b0);
        tick();
        in_valid = 1'b0;
        check("mid_state_pre", dbg_state, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_valid", out_valid, 0);
        check("mid_state", dbg_state, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_alu", out_alu_output, 0);
        tick();
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
